// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/halt controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } hz_state_t;

  localparam int unsigned REG_W_DEF        = 5;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned MEM_TIMEOUT_DEF  = 255;

  localparam int unsigned DRAIN_W = 4;
  localparam int unsigned TMO_W   = 8;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use comparator: EX load whose non-zero destination feeds a source read in ID.
module hazard_lu_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             lu
);

  // Register x0 never carries a real dependency.
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and halt controller: load-use bubbles, branch squashes,
// data-memory waits with timeout, and halt drain sequencing.
// Optional feature: HAZARD_PERF_EN builds the saturating stall_cycles counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W        = REG_W_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             resume,
  output logic             stall,
  output logic             enable_halt,
  output logic             mem_stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic             mem_err,
  output logic [15:0]      stall_cycles
);

  logic               lu;
  hz_state_t          state, state_nx;
  logic [DRAIN_W-1:0] dcnt, dcnt_nx;
  logic [TMO_W-1:0]   tcnt, tcnt_nx;
  logic               err_nx;

  hazard_lu_detect #(.REG_W(REG_W)) u_lu (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu          (lu)
  );

  // State, counters and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      dcnt    <= '0;
      tcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      dcnt    <= dcnt_nx;
      tcnt    <= tcnt_nx;
      mem_err <= err_nx;
    end
  end

  // Next state and same-cycle control outputs; everything forced low in reset.
  always_comb begin
    state_nx    = state;
    dcnt_nx     = dcnt;
    tcnt_nx     = tcnt;
    err_nx      = mem_err;
    stall       = 1'b0;
    enable_halt = 1'b0;
    mem_stall   = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    halted      = 1'b0;

    case (state)
      RUN: begin
        if (mem_busy) begin
          stall     = 1'b1;
          mem_stall = 1'b1;
          state_nx  = MEMWAIT;
          tcnt_nx   = TMO_W'(1);
        end else if (ex_branch_taken) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (lu) begin
          stall      = 1'b1;
          flush_idex = 1'b1;
        end else if (id_halt) begin
          stall       = 1'b1;
          enable_halt = 1'b1;
          flush_idex  = 1'b1;
          state_nx    = DRAIN;
          dcnt_nx     = DRAIN_W'(DRAIN_CYCLES);
        end
      end

      MEMWAIT: begin
        stall     = 1'b1;
        mem_stall = 1'b1;
        if (!mem_busy) begin
          state_nx = RUN;
        end else if (tcnt == TMO_W'(MEM_TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          state_nx = HALTED;
        end else begin
          tcnt_nx = tcnt + TMO_W'(1);
        end
      end

      DRAIN: begin
        stall       = 1'b1;
        enable_halt = 1'b1;
        flush_idex  = 1'b1;
        if (mem_busy) begin
          mem_stall = 1'b1;
        end else if (dcnt == DRAIN_W'(1)) begin
          state_nx = HALTED;
        end else begin
          dcnt_nx = dcnt - DRAIN_W'(1);
        end
      end

      HALTED: begin
        stall       = 1'b1;
        enable_halt = 1'b1;
        halted      = 1'b1;
        if (resume) begin
          state_nx = RUN;
        end
      end

      default: state_nx = RUN;
    endcase

    if (!reset) begin
      stall       = 1'b0;
      enable_halt = 1'b0;
      mem_stall   = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      halted      = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= 16'd0;
    end else if (stall && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic
// against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int DC = 3;
  localparam int MT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, id_halt, ex_mem_read;
  logic       ex_branch_taken, mem_busy, resume;
  logic       stall, enable_halt, mem_stall, flush_ifid, flush_idex, halted, mem_err;
  logic [15:0] stall_cycles;

  int vectors     = 0;
  int miscompares = 0;

  // Model: mode 0 running, 1 waiting on memory, 2 draining, 3 halted.
  int mode, drain_left, busy_run, perf;
  bit err;
  bit e_st, e_eh, e_ms, e_fi, e_fd, e_h;

  hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_halt         (id_halt),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .resume          (resume),
    .stall           (stall),
    .enable_halt     (enable_halt),
    .mem_stall       (mem_stall),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .halted          (halted),
    .mem_err         (mem_err),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit load_use();
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  task automatic model_reset();
    mode = 0; drain_left = 0; busy_run = 0; perf = 0; err = 1'b0;
  endtask

  task automatic model_outputs();
    {e_st, e_eh, e_ms, e_fi, e_fd, e_h} = 6'b0;
    if (reset) begin
      case (mode)
        0: begin
          if (mem_busy)             begin e_st = 1; e_ms = 1; end
          else if (ex_branch_taken) begin e_fi = 1; e_fd = 1; end
          else if (load_use())      begin e_st = 1; e_fd = 1; end
          else if (id_halt)         begin e_st = 1; e_eh = 1; e_fd = 1; end
        end
        1: begin e_st = 1; e_ms = 1; end
        2: begin e_st = 1; e_eh = 1; e_fd = 1; e_ms = mem_busy; end
        default: begin e_st = 1; e_eh = 1; e_h = 1; end
      endcase
    end
  endtask

  task automatic model_step();
    if (e_st && perf < 16'hFFFF) perf++;
    case (mode)
      0: begin
        if (mem_busy) begin mode = 1; busy_run = 1; end
        else if (!ex_branch_taken && !load_use() && id_halt) begin mode = 2; drain_left = DC; end
      end
      1: begin
        if (!mem_busy) mode = 0;
        else begin
          busy_run++;
          if (busy_run >= MT) begin err = 1'b1; mode = 3; end
        end
      end
      2: if (!mem_busy) begin
        drain_left--;
        if (drain_left == 0) mode = 3;
      end
      default: if (resume) mode = 0;
    endcase
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge.
  task automatic cycle();
    #1;
    if (!reset) model_reset();
    model_outputs();
    chk("stall", 16'(stall), 16'(e_st));
    chk("enable_halt", 16'(enable_halt), 16'(e_eh));
    chk("mem_stall", 16'(mem_stall), 16'(e_ms));
    chk("flush_ifid", 16'(flush_ifid), 16'(e_fi));
    chk("flush_idex", 16'(flush_idex), 16'(e_fd));
    chk("halted", 16'(halted), 16'(e_h));
    chk("mem_err", 16'(mem_err), 16'(err));
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles, 16'(perf));
`else
    chk("stall_cycles", stall_cycles, 16'd0);
`endif
    vectors++;
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_halt = 0; ex_mem_read = 0; ex_branch_taken = 0; mem_busy = 0; resume = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1; ex_rd = rd; id_rs2 = 5'd3; id_use_rs2 = 1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    model_reset();

    // Reset state, with noisy inputs that must stay masked.
    cycle();
    mem_busy = 1; id_halt = 1; set_lu(5'd3);
    cycle();
    chk("rst_stall", 16'(stall), 16'd0);
    idle();
    reset = 1'b1;
    cycle();

    // Load-use bubble, then bubble in EX clears it; ex_rd=0 never stalls.
    set_lu(5'd3);
    cycle();
    idle();
    cycle();
    set_lu(5'd0);
    cycle();
    idle();

    // Branch outranks load-use and halt.
    set_lu(5'd3); ex_branch_taken = 1; id_halt = 1;
    cycle();
    idle();
    cycle();
    chk("branch_no_drain", 16'(enable_halt), 16'd0);

    // Halt drain and resume.
    id_halt = 1;
    cycle();
    idle();
    repeat (DC) cycle();
    chk("drain_halted", 16'(halted), 16'd1);
    repeat (5) cycle();
    resume = 1;
    cycle();
    resume = 0;
    cycle();
    chk("resume_stall", 16'(stall), 16'd0);

    // Memory wait shorter than the timeout.
    mem_busy = 1;
    repeat (3) cycle();
    mem_busy = 0;
    repeat (3) cycle();
    chk("memwait_err", 16'(mem_err), 16'd0);

    // Memory timeout, sticky across resume, cleared by reset.
    mem_busy = 1;
    repeat (MT) cycle();
    mem_busy = 0;
    chk("tmo_err", 16'(mem_err), 16'd1);
    chk("tmo_halted", 16'(halted), 16'd1);
    cycle();
    resume = 1;
    cycle();
    resume = 0;
    cycle();
    chk("err_sticky", 16'(mem_err), 16'd1);
    reset = 0;
    cycle();
    reset = 1;
    cycle();

    // Reset in the middle of a drain.
    id_halt = 1;
    cycle();
    idle();
    cycle();
    reset = 0;
    cycle();
    chk("rst_drain_eh", 16'(enable_halt), 16'd0);
    reset = 1;
    cycle();

`ifdef HAZARD_PERF_EN
    // Seven load-use stalls from a fresh reset.
    reset = 0;
    cycle();
    reset = 1;
    set_lu(5'd3);
    repeat (7) cycle();
    idle();
    cycle();
    chk("perf7", stall_cycles, 16'd7);
`endif

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 9) < 4);
      ex_branch_taken = ($urandom_range(0, 9) < 2);
      id_halt         = ($urandom_range(0, 9) < 1);
      resume          = ($urandom_range(0, 9) < 2);
      mem_busy        = mem_busy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      reset           = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
